time_keeper_dp: RTL and testbench

- Parametrised successor of the stopwatch datapath: hour:min:sec:sub-second counter chain with its own prescaler.
- Generalises tick rate, clock frequency and hour modulus.
- Adds up/down (countdown timer) mode, preset load, lap capture, and terminal/wrap flags.
- Sits between the control unit (run/clear/lap/load commands from buttons or UART) and the FND/UART display formatters.

---
 rtl/time_keeper_dp.sv | 154 +++++++++++++++
 tb/tb_time_keeper_dp.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/time_keeper_dp.sv
// time_keeper_dp: prescaled hour:min:sec:sub-second up/down counter with preset load, lap capture and done/wrap pulses.
module time_keeper_dp #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int HOUR_MOD = 24,
    localparam int DIV = CLK_FREQ_HZ / TICK_HZ,
    localparam int SUB_W = $clog2(TICK_HZ),
    localparam int HOUR_W = $clog2(HOUR_MOD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_clear,
    input  logic              i_dir,
    input  logic              i_load,
    input  logic [SUB_W-1:0]  i_ld_sub,
    input  logic [5:0]        i_ld_sec,
    input  logic [5:0]        i_ld_min,
    input  logic [HOUR_W-1:0] i_ld_hour,
    input  logic              i_lap,
    output logic [SUB_W-1:0]  o_sub,
    output logic [5:0]        o_sec,
    output logic [5:0]        o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic [SUB_W-1:0]  o_lap_sub,
    output logic [5:0]        o_lap_sec,
    output logic [5:0]        o_lap_min,
    output logic [HOUR_W-1:0] o_lap_hour,
    output logic              o_lap_valid,
    output logic              o_done,
    output logic              o_wrap
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICK_HZ - 1);
    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_MOD - 1);
    localparam logic [5:0] SM_MAX = 6'd59;

    logic [PW-1:0] pre_q, pre_d;
    logic [SUB_W-1:0] sub_q, sub_d, lap_sub_q, lap_sub_d;
    logic [5:0] sec_q, sec_d, min_q, min_d, lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;
    logic [HOUR_W-1:0] hour_q, hour_d, lap_hour_q, lap_hour_d;
    logic lap_valid_q, lap_valid_d, done_q, done_d, wrap_q, wrap_d, halted_q, halted_d;

    logic run_eff, tick;
    logic sub_max, sec_max, min_max, hour_max, sub_zero, sec_zero, min_zero, hour_zero;
    logic all_max, last_one;

    assign run_eff = i_run & ~halted_q;
    assign tick = run_eff & (pre_q == PRE_MAX);
    assign sub_max = sub_q == SUB_MAX;
    assign sec_max = sec_q == SM_MAX;
    assign min_max = min_q == SM_MAX;
    assign hour_max = hour_q == HOUR_MAX;
    assign sub_zero = sub_q == '0;
    assign sec_zero = sec_q == '0;
    assign min_zero = min_q == '0;
    assign hour_zero = hour_q == '0;
    assign all_max = sub_max & sec_max & min_max & hour_max;
    // the decrement that lands exactly on all-zero
    assign last_one = (sub_q == SUB_W'(1)) & sec_zero & min_zero & hour_zero;

    always_comb begin
        pre_d = run_eff ? (tick ? '0 : pre_q + 1'b1) : pre_q;
        sub_d = sub_q;
        sec_d = sec_q;
        min_d = min_q;
        hour_d = hour_q;
        done_d = 1'b0;
        wrap_d = 1'b0;
        halted_d = halted_q & i_run;
        if (i_clear) begin
            pre_d = '0;
            sub_d = '0;
            sec_d = '0;
            min_d = '0;
            hour_d = '0;
            halted_d = 1'b0;
        end else if (i_load) begin
            pre_d = '0;
            sub_d = (i_ld_sub > SUB_MAX) ? SUB_MAX : i_ld_sub;
            sec_d = (i_ld_sec > SM_MAX) ? SM_MAX : i_ld_sec;
            min_d = (i_ld_min > SM_MAX) ? SM_MAX : i_ld_min;
            hour_d = (i_ld_hour > HOUR_MAX) ? HOUR_MAX : i_ld_hour;
            halted_d = 1'b0;
        end else if (tick && i_dir) begin
            sub_d = sub_zero ? SUB_MAX : sub_q - 1'b1;
            sec_d = sub_zero ? (sec_zero ? SM_MAX : sec_q - 1'b1) : sec_q;
            min_d = (sub_zero & sec_zero) ? (min_zero ? SM_MAX : min_q - 1'b1) : min_q;
            hour_d = (sub_zero & sec_zero & min_zero) ? (hour_zero ? HOUR_MAX : hour_q - 1'b1) : hour_q;
            done_d = last_one;
            halted_d = last_one;
        end else if (tick) begin
            sub_d = sub_max ? '0 : sub_q + 1'b1;
            sec_d = sub_max ? (sec_max ? '0 : sec_q + 1'b1) : sec_q;
            min_d = (sub_max & sec_max) ? (min_max ? '0 : min_q + 1'b1) : min_q;
            hour_d = (sub_max & sec_max & min_max) ? (hour_max ? '0 : hour_q + 1'b1) : hour_q;
            wrap_d = all_max;
        end
    end

    // lap snapshots the pre-edge live registers; clear wins over a capture
    always_comb begin
        lap_sub_d = i_clear ? '0 : (i_lap ? sub_q : lap_sub_q);
        lap_sec_d = i_clear ? '0 : (i_lap ? sec_q : lap_sec_q);
        lap_min_d = i_clear ? '0 : (i_lap ? min_q : lap_min_q);
        lap_hour_d = i_clear ? '0 : (i_lap ? hour_q : lap_hour_q);
        lap_valid_d = ~i_clear & (i_lap | lap_valid_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q <= '0;
            sub_q <= '0;
            sec_q <= '0;
            min_q <= '0;
            hour_q <= '0;
            lap_sub_q <= '0;
            lap_sec_q <= '0;
            lap_min_q <= '0;
            lap_hour_q <= '0;
            lap_valid_q <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            sub_q <= sub_d;
            sec_q <= sec_d;
            min_q <= min_d;
            hour_q <= hour_d;
            lap_sub_q <= lap_sub_d;
            lap_sec_q <= lap_sec_d;
            lap_min_q <= lap_min_d;
            lap_hour_q <= lap_hour_d;
            lap_valid_q <= lap_valid_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
            halted_q <= halted_d;
        end
    end

    assign o_sub = sub_q;
    assign o_sec = sec_q;
    assign o_min = min_q;
    assign o_hour = hour_q;
    assign o_lap_sub = lap_sub_q;
    assign o_lap_sec = lap_sec_q;
    assign o_lap_min = lap_min_q;
    assign o_lap_hour = lap_hour_q;
    assign o_lap_valid = lap_valid_q;
    assign o_done = done_q;
    assign o_wrap = wrap_q;
endmodule

// File: tb/tb_time_keeper_dp.sv
// tb_time_keeper_dp: table-driven scoreboard bench for time_keeper_dp at 1 kHz clock, 100 Hz tick, 24 h.
module tb_time_keeper_dp;
    logic clk = 1'b0;
    logic rst, i_run, i_clear, i_dir, i_load, i_lap;
    logic [6:0] i_ld_sub, o_sub, o_lap_sub;
    logic [5:0] i_ld_sec, i_ld_min, o_sec, o_min, o_lap_sec, o_lap_min;
    logic [4:0] i_ld_hour, o_hour, o_lap_hour;
    logic o_lap_valid, o_done, o_wrap;

    time_keeper_dp #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .HOUR_MOD(24)) dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_clear(i_clear), .i_dir(i_dir), .i_load(i_load),
        .i_ld_sub(i_ld_sub), .i_ld_sec(i_ld_sec), .i_ld_min(i_ld_min), .i_ld_hour(i_ld_hour),
        .i_lap(i_lap), .o_sub(o_sub), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_lap_sub(o_lap_sub), .o_lap_sec(o_lap_sec), .o_lap_min(o_lap_min), .o_lap_hour(o_lap_hour),
        .o_lap_valid(o_lap_valid), .o_done(o_done), .o_wrap(o_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int run, dir, clr, ld, lap;
        int lh, lm, ls, lsub;
        int cyc;
        int eh, em, es, esub;
        int tag;
    } vec_t;

    typedef struct {
        string name;
        int h, m, s, sub;
    } exp_t;

    vec_t tbl[26];
    exp_t exp_q[$];
    int n_chk = 0, n_pass = 0;
    int wrap_cnt = 0, done_cnt = 0, dbl_cnt = 0;
    logic prev_wrap = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin
        wrap_cnt <= wrap_cnt + ((o_wrap === 1'b1) ? 1 : 0);
        done_cnt <= done_cnt + ((o_done === 1'b1) ? 1 : 0);
        dbl_cnt <= dbl_cnt + (((o_wrap === 1'b1 && prev_wrap) || (o_done === 1'b1 && prev_done)) ? 1 : 0);
        prev_wrap <= (o_wrap === 1'b1);
        prev_done <= (o_done === 1'b1);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        tbl[0]  = '{"up_first9",   1,0,0,0,0,  0, 0, 0,  0,   9,   0, 0, 0,  0, 0};
        tbl[1]  = '{"up_first10",  1,0,0,0,0,  0, 0, 0,  0,   1,   0, 0, 0,  1, 0};
        tbl[2]  = '{"up_1s",       1,0,0,0,0,  0, 0, 0,  0, 990,   0, 0, 1,  0, 0};
        tbl[3]  = '{"ld_max",      1,0,0,1,0, 23,59,59, 99,   1,  23,59,59, 99, 0};
        tbl[4]  = '{"rollover",    1,0,0,0,0,  0, 0, 0,  0,  10,   0, 0, 0,  0, 1};
        tbl[5]  = '{"roll_cont",   1,0,0,0,0,  0, 0, 0,  0,  10,   0, 0, 0,  1, 2};
        tbl[6]  = '{"clamp",       0,0,0,1,0, 31,63,63,120,   1,  23,59,59, 99, 0};
        tbl[7]  = '{"cd_load",     1,1,0,1,0,  0, 0, 1,  0,   1,   0, 0, 1,  0, 0};
        tbl[8]  = '{"cd_first",    1,1,0,0,0,  0, 0, 0,  0,  10,   0, 0, 0, 99, 0};
        tbl[9]  = '{"cd_zero",     1,1,0,0,0,  0, 0, 0,  0, 990,   0, 0, 0,  0, 3};
        tbl[10] = '{"cd_hold",     1,1,0,0,0,  0, 0, 0,  0, 100,   0, 0, 0,  0, 4};
        tbl[11] = '{"rearm_off",   0,1,0,0,0,  0, 0, 0,  0,   1,   0, 0, 0,  0, 0};
        tbl[12] = '{"rearm_on",    1,1,0,0,0,  0, 0, 0,  0,   5,   0, 0, 0,  0, 0};
        tbl[13] = '{"lap_load",    1,0,0,1,0,  0, 0, 3, 40,   1,   0, 0, 3, 40, 0};
        tbl[14] = '{"to_342",      1,0,0,0,0,  0, 0, 0,  0,  20,   0, 0, 3, 42, 0};
        tbl[15] = '{"lap_take",    1,0,0,0,1,  0, 0, 0,  0,   1,   0, 0, 3, 42, 5};
        tbl[16] = '{"lap_frozen",  1,0,0,0,0,  0, 0, 0,  0,  29,   0, 0, 3, 45, 5};
        tbl[17] = '{"pre9",        1,0,0,0,0,  0, 0, 0,  0,   9,   0, 0, 3, 45, 0};
        tbl[18] = '{"clr_ld_tick", 1,0,1,1,1,  0, 0, 5,  5,   1,   0, 0, 0,  0, 6};
        tbl[19] = '{"post_clr9",   1,0,0,0,0,  0, 0, 0,  0,   9,   0, 0, 0,  0, 0};
        tbl[20] = '{"post_clr10",  1,0,0,0,0,  0, 0, 0,  0,   1,   0, 0, 0,  1, 0};
        tbl[21] = '{"stop_at7",    1,0,0,0,0,  0, 0, 0,  0,   7,   0, 0, 0,  1, 0};
        tbl[22] = '{"stopped",     0,0,0,0,0,  0, 0, 0,  0,  20,   0, 0, 0,  1, 0};
        tbl[23] = '{"resume2",     1,0,0,0,0,  0, 0, 0,  0,   2,   0, 0, 0,  1, 0};
        tbl[24] = '{"resume3",     1,0,0,0,0,  0, 0, 0,  0,   1,   0, 0, 0,  2, 0};
        tbl[25] = '{"lap2",        1,0,0,0,1,  0, 0, 0,  0,   3,   0, 0, 0,  2, 7};
        rst = 1'b0;
        {i_run, i_clear, i_dir, i_load, i_lap} = '0;
        {i_ld_sub, i_ld_sec, i_ld_min, i_ld_hour} = '0;
        step(3);
        check("rst_sub", int'(o_sub), 0);
        check("rst_sec", int'(o_sec), 0);
        check("rst_hour", int'(o_hour), 0);
        check("rst_lap_valid", int'(o_lap_valid), 0);
        check("rst_flags", int'({o_done, o_wrap}), 0);
        rst = 1'b1;
        for (int i = 0; i < 26; i++) begin
            i_run = tbl[i].run != 0;
            i_dir = tbl[i].dir != 0;
            i_clear = tbl[i].clr != 0;
            i_load = tbl[i].ld != 0;
            i_lap = tbl[i].lap != 0;
            i_ld_hour = 5'(tbl[i].lh);
            i_ld_min = 6'(tbl[i].lm);
            i_ld_sec = 6'(tbl[i].ls);
            i_ld_sub = 7'(tbl[i].lsub);
            exp_q.push_back('{tbl[i].name, tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].esub});
            step(1);
            {i_clear, i_load, i_lap} = '0;
            if (tbl[i].cyc > 1) step(tbl[i].cyc - 1);
            e = exp_q.pop_front();
            check({e.name, "_hour"}, int'(o_hour), e.h);
            check({e.name, "_min"}, int'(o_min), e.m);
            check({e.name, "_sec"}, int'(o_sec), e.s);
            check({e.name, "_sub"}, int'(o_sub), e.sub);
            case (tbl[i].tag)
                1: check("wrap_pulse", int'(o_wrap), 1);
                2: check("wrap_once", wrap_cnt, 1);
                3: check("done_pulse", int'(o_done), 1);
                4: begin
                    check("done_once", done_cnt, 1);
                    check("done_low", int'(o_done), 0);
                end
                5: begin
                    check("lap_hour", int'(o_lap_hour), 0);
                    check("lap_min", int'(o_lap_min), 0);
                    check("lap_sec", int'(o_lap_sec), 3);
                    check("lap_sub", int'(o_lap_sub), 42);
                    check("lap_valid", int'(o_lap_valid), 1);
                end
                6: begin
                    check("clr_lap_valid", int'(o_lap_valid), 0);
                    check("clr_lap_sec", int'(o_lap_sec), 0);
                    check("clr_no_pulse", int'({o_done, o_wrap}), 0);
                end
                7: begin
                    check("lap2_sub", int'(o_lap_sub), 2);
                    check("lap2_valid", int'(o_lap_valid), 1);
                end
                default: ;
            endcase
        end
        rst = 1'b0;
        step(1);
        check("midrst_time", int'({o_hour, o_min, o_sec, o_sub}), 0);
        check("midrst_lap", int'({o_lap_hour, o_lap_min, o_lap_sec, o_lap_sub}), 0);
        check("midrst_flags", int'({o_lap_valid, o_done, o_wrap}), 0);
        rst = 1'b1;
        step(2);
        check("total_wraps", wrap_cnt, 1);
        check("total_dones", done_cnt, 1);
        check("no_double_pulse", dbl_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
